gpr_shift_ctrl: RTL and testbench

- Command sequencer for the 4-bit universal shift register (GPR: CLR, CLK, r_in, l_in, S[1:0], X[3:0], Q[3:0]).
- Accepts one command at a time over a valid/ready handshake: load, clear, or N-step logical/rotate/arithmetic shift.
- Drives the GPR mode/data/serial inputs cycle by cycle, using GPR Q as feedback for rotate and arithmetic fills.
- Pulses done on completion; the sole master of the GPR control pins.

---
 rtl/gpr_shift_ctrl.sv | 124 ++++++++++++
 tb/tb_gpr_shift_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gpr_shift_ctrl.sv
// Command sequencer for a 4-bit universal shift register (GPR).
// Turns load/clear/N-step shift commands into cycle-by-cycle S/X/r_in/l_in drive.
module gpr_shift_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             abort,
    input  logic [WIDTH-1:0] Q,
    output logic [1:0]       S,
    output logic [WIDTH-1:0] X,
    output logic             r_in,
    output logic             l_in,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
    typedef enum logic [2:0] {
        OP_LOAD, OP_SHR, OP_SHL, OP_ROR, OP_ROL, OP_ASR, OP_CLEAR, OP_RSVD
    } op_t;

    localparam logic [1:0] S_HOLD  = 2'b00;
    localparam logic [1:0] S_RIGHT = 2'b01;
    localparam logic [1:0] S_LEFT  = 2'b10;
    localparam logic [1:0] S_LOAD  = 2'b11;

    state_t            state, state_nx;
    op_t               op;
    logic [CNT_W-1:0]  rem;
    logic [WIDTH-1:0]  data;
    logic              accept;
    op_t               cmd_op_t;

    // Only the end bits of Q feed the serial inputs; the rest is intentionally unused.
    logic unused_q;
    assign unused_q = ^Q;

    assign cmd_op_t = op_t'(cmd_op);
    assign accept   = cmd_valid && (state == IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            op   <= OP_LOAD;
            rem  <= '0;
            data <= '0;
        end else if (accept) begin
            op   <= cmd_op_t;
            rem  <= cmd_cnt;
            data <= cmd_data;
        end else if (state == SHIFT && !abort) begin
            rem <= rem - CNT_W'(1);
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    unique case (cmd_op_t)
                        OP_LOAD, OP_CLEAR:                    state_nx = LOAD;
                        OP_SHR, OP_SHL, OP_ROR, OP_ROL, OP_ASR:
                            state_nx = (cmd_cnt != '0) ? SHIFT : DONE;
                        default:                              state_nx = DONE;
                    endcase
                end
            end
            LOAD:  state_nx = DONE;
            SHIFT: if (abort || rem == CNT_W'(1)) state_nx = DONE;
            DONE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        S         = S_HOLD;
        X         = data;
        r_in      = 1'b0;
        l_in      = 1'b0;
        busy      = (state != IDLE);
        cmd_ready = (state == IDLE);
        done      = 1'b0;
        err       = 1'b0;
        unique case (state)
            LOAD: begin
                S = S_LOAD;
                X = (op == OP_CLEAR) ? '0 : data;
            end
            SHIFT: begin
                unique case (op)
                    OP_SHR: S = S_RIGHT;
                    OP_ROR: begin S = S_RIGHT; r_in = Q[0];       end
                    OP_ASR: begin S = S_RIGHT; r_in = Q[WIDTH-1]; end
                    OP_SHL: S = S_LEFT;
                    OP_ROL: begin S = S_LEFT;  l_in = Q[WIDTH-1]; end
                    default: S = S_HOLD;
                endcase
                // An abort cycle performs no shift; the state still moves to DONE.
                if (abort) S = S_HOLD;
            end
            DONE: begin
                done = 1'b1;
                err  = (op == OP_RSVD);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_gpr_shift_ctrl.sv
// Bench for gpr_shift_ctrl: a GPR model closes the Q loop; a command-level
// model predicts every cycle's controller outputs and each command's final Q.
module tb_gpr_shift_ctrl;

    logic       CLK = 1'b0;
    logic       CLR = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_op = '0;
    logic [2:0] cmd_cnt = '0;
    logic [3:0] cmd_data = '0;
    logic       abort = 1'b0;
    logic [3:0] Q;
    logic [1:0] S;
    logic [3:0] X;
    logic       r_in, l_in, busy, done, err;

    gpr_shift_ctrl #(.WIDTH(4), .CNT_W(3)) dut (
        .CLK(CLK), .CLR(CLR), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_cnt(cmd_cnt), .cmd_data(cmd_data), .abort(abort),
        .Q(Q), .S(S), .X(X), .r_in(r_in), .l_in(l_in),
        .busy(busy), .done(done), .err(err)
    );

    always #5 CLK = ~CLK;

    // The GPR itself.
    always @(posedge CLK or posedge CLR) begin
        if (CLR) Q <= 4'b0000;
        else case (S)
            2'b01: Q <= {r_in, Q[3:1]};
            2'b10: Q <= {Q[2:0], l_in};
            2'b11: Q <= X;
            default: Q <= Q;
        endcase
    end

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    localparam logic [2:0] LD = 3'd0, SHR = 3'd1, SHL = 3'd2, ROR = 3'd3,
                           ROL = 3'd4, ASR = 3'd5, CLRQ = 3'd6, RSV = 3'd7;

    // ser: 0 = both serial inputs must be 0, 1 = shift fill rule applies, 2 = not checked
    typedef struct {
        int         cyc;
        logic [1:0] s;
        logic       busy;
        logic       done;
        logic       err;
        int         ser;
        logic [2:0] op;
        logic       chk_x;
        logic [3:0] x;
        logic       chk_q;
        logic [3:0] q;
    } exp_t;

    exp_t       expq[$];
    logic [3:0] mdl_q = 4'b0000;
    bit         mon_en = 1'b0;
    int         checks = 0;
    int         errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, req);
        end
    endtask

    function automatic exp_t mk(input int c, input logic [1:0] s, input logic b,
                                input logic d, input logic e, input int ser, input logic [2:0] op);
        exp_t r;
        r.cyc = c; r.s = s; r.busy = b; r.done = d; r.err = e; r.ser = ser; r.op = op;
        r.chk_x = 1'b0; r.x = '0; r.chk_q = 1'b0; r.q = '0;
        return r;
    endfunction

    // Issue one command; abort_at = k aborts on the k-th SHIFT cycle (0 = none).
    // With blocking=0 the task returns one cycle after acceptance.
    task automatic issue(input logic [2:0] op, input logic [2:0] cnt, input logic [3:0] data,
                         input int abort_at, input bit blocking);
        int               n;
        int               eff;
        int               base;
        int               total;
        logic [3:0]       q1;
        logic [7:0]       dq;
        logic signed [3:0] sq;
        exp_t             e;
        cmd_valid = 1'b1; cmd_op = op; cmd_cnt = cnt; cmd_data = data;
        n = 0;
        while (!cmd_ready && n < 100) begin @(posedge CLK); #1; n++; end
        if (!cmd_ready) begin
            check("accept_timeout", 32'(cmd_ready), 32'd1);
            cmd_valid = 1'b0;
            return;
        end
        base = cyc;
        eff  = (op >= SHR && op <= ASR) ? ((abort_at > 0) ? abort_at - 1 : int'(cnt)) : 0;
        case (op)
            LD:   q1 = data;
            CLRQ: q1 = 4'b0000;
            SHR:  q1 = mdl_q >> eff;
            SHL:  q1 = mdl_q << eff;
            ROR:  begin dq = {mdl_q, mdl_q} >> (eff % 4); q1 = dq[3:0]; end
            ROL:  begin dq = {mdl_q, mdl_q} << (eff % 4); q1 = dq[7:4]; end
            ASR:  begin sq = mdl_q; sq = sq >>> eff; q1 = sq; end
            default: q1 = mdl_q;
        endcase
        total = 0;
        if (op == LD || op == CLRQ) begin
            e = mk(base + 1, 2'b11, 1'b1, 1'b0, 1'b0, 0, op);
            e.chk_x = 1'b1; e.x = (op == LD) ? data : 4'b0000;
            expq.push_back(e);
            total = 1;
        end else if (op >= SHR && op <= ASR && cnt != 0) begin
            for (int i = 1; i <= eff; i++)
                expq.push_back(mk(base + i, (op == SHL || op == ROL) ? 2'b10 : 2'b01,
                                  1'b1, 1'b0, 1'b0, 1, op));
            total = eff;
            if (abort_at > 0) begin
                expq.push_back(mk(base + total + 1, 2'b00, 1'b1, 1'b0, 1'b0, 2, op));
                total++;
            end
        end
        e = mk(base + total + 1, 2'b00, 1'b1, 1'b1, (op == RSV), 0, op);
        e.chk_q = 1'b1; e.q = q1;
        expq.push_back(e);
        total++;
        mdl_q = q1;
        @(posedge CLK); #1;
        cmd_valid = 1'b0;
        if (blocking) begin
            for (int i = 1; i <= total; i++) begin
                abort = (i == abort_at);
                @(posedge CLK); #1;
            end
            abort = 1'b0;
        end
    endtask

    // Per-cycle compare against the model, mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK); #1;
            if (mon_en) begin
                if (expq.size() > 0 && expq[0].cyc == cyc) begin
                    e = expq.pop_front();
                    check("S", 32'(S), 32'(e.s));
                    check("busy", 32'(busy), 32'(e.busy));
                    check("done", 32'(done), 32'(e.done));
                    check("err", 32'(err), 32'(e.err));
                    check("cmd_ready", 32'(cmd_ready), 32'd0);
                    if (e.chk_x) check("X_load", 32'(X), 32'(e.x));
                    if (e.chk_q) check("Q_final", 32'(Q), 32'(e.q));
                    if (e.ser == 0) begin
                        check("r_in_idle", 32'(r_in), 32'd0);
                        check("l_in_idle", 32'(l_in), 32'd0);
                    end else if (e.ser == 1) begin
                        case (e.op)
                            ROR:     check("r_in_ror", 32'(r_in), 32'(Q[0]));
                            ASR:     check("r_in_asr", 32'(r_in), 32'(Q[3]));
                            ROL:     check("l_in_rol", 32'(l_in), 32'(Q[3]));
                            SHR:     check("r_in_shr", 32'(r_in), 32'd0);
                            default: check("l_in_shl", 32'(l_in), 32'd0);
                        endcase
                        if (e.op == SHL || e.op == ROL) check("r_in_unused", 32'(r_in), 32'd0);
                        else                            check("l_in_unused", 32'(l_in), 32'd0);
                    end
                end else begin
                    check("idle_S", 32'(S), 32'd0);
                    check("idle_busy", 32'(busy), 32'd0);
                    check("idle_done", 32'(done), 32'd0);
                    check("idle_err", 32'(err), 32'd0);
                    check("idle_ready", 32'(cmd_ready), 32'd1);
                    check("idle_serial", 32'({r_in, l_in}), 32'd0);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        check("rst_S", 32'(S), 32'd0);
        check("rst_X", 32'(X), 32'd0);
        check("rst_serial", 32'({r_in, l_in}), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done_err", 32'({done, err}), 32'd0);
        check("rst_ready", 32'(cmd_ready), 32'd1);
        #11;
        CLR = 1'b0;
        mon_en = 1'b1;
        @(posedge CLK); #1;

        issue(LD, 3'd0, 4'b1011, 0, 1'b1);   check("lit_load",  32'(Q), 32'b1011);
        issue(CLRQ, 3'd0, 4'b0000, 0, 1'b1); check("lit_clear", 32'(Q), 32'b0000);
        issue(LD, 3'd0, 4'b1011, 0, 1'b1);
        issue(ROR, 3'd1, 4'b0000, 0, 1'b1);  check("lit_ror1", 32'(Q), 32'b1101);
        issue(LD, 3'd0, 4'b1011, 0, 1'b1);
        issue(ROL, 3'd2, 4'b0000, 0, 1'b1);  check("lit_rol2", 32'(Q), 32'b1110);
        issue(LD, 3'd0, 4'b1000, 0, 1'b1);
        issue(ASR, 3'd2, 4'b0000, 0, 1'b1);  check("lit_asr2", 32'(Q), 32'b1110);
        issue(LD, 3'd0, 4'b0011, 0, 1'b1);
        issue(SHL, 3'd3, 4'b0000, 0, 1'b1);  check("lit_shl3", 32'(Q), 32'b1000);
        issue(SHR, 3'd0, 4'b0110, 0, 1'b1);  check("lit_shr0", 32'(Q), 32'b1000);
        issue(RSV, 3'd3, 4'b0110, 0, 1'b1);  check("lit_rsvd", 32'(Q), 32'b1000);
        issue(SHR, 3'd2, 4'b0000, 0, 1'b1);  check("lit_shr2", 32'(Q), 32'b0010);
        issue(LD, 3'd0, 4'b0001, 0, 1'b1);
        issue(ROR, 3'd5, 4'b0000, 3, 1'b1);  check("lit_abort", 32'(Q), 32'b0100);
        issue(LD, 3'd0, 4'b1011, 0, 1'b1);
        issue(ROR, 3'd7, 4'b0000, 0, 1'b1);  check("lit_ror7", 32'(Q), 32'b0111);
        issue(ASR, 3'd7, 4'b0000, 0, 1'b1);  check("lit_asr7", 32'(Q), 32'b0000);

        // Second command presented while the first is still busy.
        issue(LD, 3'd0, 4'b0101, 0, 1'b0);
        issue(SHL, 3'd1, 4'b0000, 0, 1'b1);  check("lit_held", 32'(Q), 32'b1010);

        // Asynchronous reset in the middle of a long rotate.
        issue(ROR, 3'd7, 4'b0000, 0, 1'b0);
        repeat (2) @(posedge CLK);
        #3;
        mon_en = 1'b0;
        CLR = 1'b1;
        #1;
        check("clr_S", 32'(S), 32'd0);
        check("clr_busy", 32'(busy), 32'd0);
        check("clr_done", 32'(done), 32'd0);
        check("clr_ready", 32'(cmd_ready), 32'd1);
        check("clr_serial", 32'({r_in, l_in}), 32'd0);
        expq.delete();
        mdl_q = 4'b0000;
        @(posedge CLK); #2;
        CLR = 1'b0;
        mon_en = 1'b1;
        @(posedge CLK); #1;
        check("clr_q", 32'(Q), 32'd0);
        issue(LD, 3'd0, 4'b1001, 0, 1'b1);
        issue(ROL, 3'd1, 4'b0000, 0, 1'b1);  check("lit_post_clr", 32'(Q), 32'b0011);

        repeat (3) @(posedge CLK);
        #1;
        if (expq.size() != 0) check("queue_drained", 32'(expq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
